conv_window_sched: RTL and testbench

Raster-scan scheduler that time-multiplexes a single SIZEKer×SIZEKer convolution engine across a SIZE×SIZE input image. On `start` it walks every valid window top-left position and tells the engine which window to capture. It waits the engine's fixed latency, then writes each result, optionally ReLU-clipped, to the output feature-map buffer under a ready/write handshake. It sits between the layer controller (start/done) and the conv engine plus output buffer.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/window_counter.sv | 62 ++++++
 rtl/conv_window_sched.sv | 169 ++++++++++++++++
 tb/tb_conv_window_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//
// Shared definitions for the convolution window scheduler slice:
//   - conv_sched_state_t : scheduler FSM state encoding
//   - conv_out_dim()     : output feature-map edge length for a valid conv
//   - conv_idx_w()       : bit width of a row/col index into the image
//   - conv_lat_w()       : bit width of the engine latency counter
//
// No ports; imported by conv_window_sched and window_counter.
// ---------------------------------------------------------------------------
package conv_pkg;

  // Scheduler states, one per phase of a window's life cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } conv_sched_state_t;

  // Number of valid window positions along one edge (no padding, stride 1).
  function automatic int conv_out_dim(input int size, input int size_ker);
    return size - size_ker + 1;
  endfunction

  // Index width for coordinates into a size-wide image; never below one bit.
  function automatic int conv_idx_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Width of a counter that runs 0 .. lat-1; never below one bit.
  function automatic int conv_lat_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/window_counter.sv
// ---------------------------------------------------------------------------
// window_counter
//
// Raster-order row/col counter for window top-left positions. Column runs
// fastest; at column OUT-1 it wraps to 0 and the row advances.
//
// Parameters:
//   OUT   - number of positions per edge
//   IDX_W - width of the row/col outputs
// Ports:
//   clock  in   posedge clock
//   nreset in   asynchronous active-low reset (row = col = 0)
//   inc    in   advance one raster position
//   clear  in   return to (0,0); wins over inc
//   row    out  current row index
//   col    out  current column index
//   last   out  high when row = col = OUT-1
// ---------------------------------------------------------------------------
module window_counter
  import conv_pkg::*;
#(
  parameter int OUT   = 6,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             inc,
  input  logic             clear,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT - 1);

  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] col_q;

  // The scheduler never issues inc at the last position, so row stays
  // within 0 .. OUT-1 without an explicit saturation check.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (col_q == LAST_IDX) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/conv_window_sched.sv
// ---------------------------------------------------------------------------
// conv_window_sched
//
// Raster-scan scheduler that time-shares one SIZEKer x SIZEKer conv engine
// over a SIZE x SIZE image. For each valid window it pulses win_valid,
// waits CONV_LAT cycles for the engine, captures the result and writes it
// to the output feature-map buffer with a ready/write handshake.
//
// Build option:
//   CONV_RELU_EN - when defined, negative engine results are clipped to 0
//                  as they are captured into out_data.
//
// Parameters: SIZE, SIZEKer, WIDTH_BIT, CONV_LAT (>= 1)
// Ports:
//   clock        in   posedge clock
//   nreset       in   asynchronous active-low reset
//   start        in   begin a full-image pass (honoured only when idle)
//   busy         out  high whenever the scheduler is not idle
//   done         out  one-cycle pulse after the last result is written
//   win_valid    out  engine captures window (win_row, win_col) this cycle
//   win_row/col  out  window top-left indices
//   conv_result  in   engine result, valid CONV_LAT cycles after win_valid
//   out_ready    in   output buffer can accept a write
//   out_wr_en    out  write strobe; write happens on out_wr_en && out_ready
//   out_row/col  out  output coordinate (same as window coordinate)
//   out_data     out  result to store
// ---------------------------------------------------------------------------
module conv_window_sched
  import conv_pkg::*;
#(
  parameter  int SIZE      = 8,
  parameter  int SIZEKer   = 3,
  parameter  int WIDTH_BIT = 8,
  parameter  int CONV_LAT  = 1,
  localparam int IDX_W     = conv_idx_w(SIZE)
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        win_valid,
  output logic [IDX_W-1:0]            win_row,
  output logic [IDX_W-1:0]            win_col,
  input  logic signed [WIDTH_BIT-1:0] conv_result,
  input  logic                        out_ready,
  output logic                        out_wr_en,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col,
  output logic signed [WIDTH_BIT-1:0] out_data
);

  localparam int               OUT      = conv_out_dim(SIZE, SIZEKer);
  localparam int               LAT_W    = conv_lat_w(CONV_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CONV_LAT - 1);

  conv_sched_state_t           state_q;
  logic [LAT_W-1:0]            lat_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        win_valid_q;
  logic                        out_wr_en_q;
  logic signed [WIDTH_BIT-1:0] out_data_q;
  logic signed [WIDTH_BIT-1:0] out_data_d;

  logic                        cnt_inc;
  logic                        cnt_clear;
  logic                        cnt_last;
  logic [IDX_W-1:0]            cnt_row;
  logic [IDX_W-1:0]            cnt_col;

  // The counter moves only on an accepted non-final write, so the position
  // it holds is the one being loaded, waited on and written.
  assign cnt_clear = (state_q == S_IDLE) && start;
  assign cnt_inc   = (state_q == S_WRITE) && out_ready && !cnt_last;

  window_counter #(
    .OUT   (OUT),
    .IDX_W (IDX_W)
  ) u_window_counter (
    .clock  (clock),
    .nreset (nreset),
    .inc    (cnt_inc),
    .clear  (cnt_clear),
    .row    (cnt_row),
    .col    (cnt_col),
    .last   (cnt_last)
  );

  // Value captured at the end of WAIT.
`ifdef CONV_RELU_EN
  assign out_data_d = conv_result[WIDTH_BIT-1] ? '0 : conv_result;
`else
  assign out_data_d = conv_result;
`endif

  // Scheduler FSM. Strobes are registered and raised on the edge that
  // enters their state, so win_valid coincides with LOAD, out_wr_en with
  // WRITE and done with FIN.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      out_wr_en_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            win_valid_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT;
          lat_q   <= '0;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q     <= S_WRITE;
            out_data_q  <= out_data_d;
            out_wr_en_q <= 1'b1;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_WRITE: begin
          // Backpressure simply holds this state; the engine is not relaunched.
          if (out_ready) begin
            out_wr_en_q <= 1'b0;
            if (cnt_last) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_LOAD;
              win_valid_q <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_valid = win_valid_q;
  assign win_row   = cnt_row;
  assign win_col   = cnt_col;
  assign out_wr_en = out_wr_en_q;
  assign out_row   = cnt_row;
  assign out_col   = cnt_col;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sched
//
// Directed bench for conv_window_sched. One instance runs with CONV_LAT=1
// and carries most of the scenarios; a second instance with CONV_LAT=3
// checks launch spacing and result alignment. Engine models return a value
// derived from the window coordinate so misordered or mistimed captures
// show up as data errors. Expected data follows CONV_RELU_EN if defined.
// ---------------------------------------------------------------------------
module tb_conv_window_sched;

  localparam int OUT = 6;

  logic clock;
  logic nreset, nreset3;
  logic start, start3;
  logic outReady, outReady3;

  logic              busy, done, winValid, outWrEn;
  logic [2:0]        winRow, winCol, outRow, outCol;
  logic signed [7:0] convResult, outData;

  logic              busy3, done3, winValid3, outWrEn3;
  logic [2:0]        winRow3, winCol3, outRow3, outCol3;
  logic signed [7:0] convResult3, outData3;
  logic signed [7:0] pipe1, pipe2, pipe3;

  int assertCount = 0;
  int failCount   = 0;
  int edgeCount   = 0;
  int startEdge   = 0;
  bit constMode   = 0;

  int loadIdx, writeIdx, doneCount, doneEdge, stallCycles;
  bit donePrev;
  int loadIdx3, writeIdx3, doneCount3, doneEdge3, lastWin3;

  conv_window_sched #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(8), .CONV_LAT(1)) dut (
    .clock(clock), .nreset(nreset), .start(start), .busy(busy), .done(done),
    .win_valid(winValid), .win_row(winRow), .win_col(winCol),
    .conv_result(convResult), .out_ready(outReady), .out_wr_en(outWrEn),
    .out_row(outRow), .out_col(outCol), .out_data(outData)
  );

  conv_window_sched #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(8), .CONV_LAT(3)) dut3 (
    .clock(clock), .nreset(nreset3), .start(start3), .busy(busy3), .done(done3),
    .win_valid(winValid3), .win_row(winRow3), .win_col(winCol3),
    .conv_result(convResult3), .out_ready(outReady3), .out_wr_en(outWrEn3),
    .out_row(outRow3), .out_col(outCol3), .out_data(outData3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edgeCount++;

  function automatic logic signed [7:0] engineVal(input int r, input int c);
    if (constMode) return -8'sd5;
    return 8'(r * 8 + c - 20);
  endfunction

  function automatic logic signed [7:0] expData(input logic signed [7:0] v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 8'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", tag, observed, expected, edgeCount);
    end
  endtask

  // Engine with one cycle of latency: result appears the cycle after capture.
  initial convResult = '0;
  always @(posedge clock) if (winValid) convResult <= engineVal(int'(winRow), int'(winCol));

  // Engine with three cycles of latency; idle slots carry a marker value
  // that no real window produces.
  always @(posedge clock) begin
    pipe1 <= winValid3 ? engineVal(int'(winRow3), int'(winCol3)) : 8'sh7F;
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign convResult3 = pipe3;

  // Scoreboard for the CONV_LAT=1 instance.
  always @(negedge clock) begin
    if (nreset) begin
      if (winValid) begin
        checkOutput("win_row", winRow, loadIdx / OUT);
        checkOutput("win_col", winCol, loadIdx % OUT);
        loadIdx++;
      end
      if (outWrEn) begin
        checkOutput("out_row", outRow, writeIdx / OUT);
        checkOutput("out_col", outCol, writeIdx % OUT);
        checkOutput("out_data", outData, expData(engineVal(writeIdx / OUT, writeIdx % OUT)));
        if (outReady) writeIdx++;
        else begin
          stallCycles++;
          checkOutput("stall_win_valid", winValid, 0);
        end
      end
      if (done) begin
        doneCount++;
        doneEdge = edgeCount;
        checkOutput("done_busy", busy, 1);
        checkOutput("done_writes", writeIdx, OUT * OUT);
      end
      if (donePrev) checkOutput("busy_fall", busy, 0);
      donePrev = done;
    end
  end

  // Scoreboard for the CONV_LAT=3 instance.
  always @(negedge clock) begin
    if (nreset3) begin
      if (winValid3) begin
        if (loadIdx3 > 0) checkOutput("lat3_spacing", edgeCount - lastWin3, 5);
        checkOutput("lat3_win_col", winCol3, loadIdx3 % OUT);
        lastWin3 = edgeCount;
        loadIdx3++;
      end
      if (outWrEn3 && outReady3) begin
        checkOutput("lat3_out_row", outRow3, writeIdx3 / OUT);
        checkOutput("lat3_out_col", outCol3, writeIdx3 % OUT);
        checkOutput("lat3_out_data", outData3, expData(engineVal(writeIdx3 / OUT, writeIdx3 % OUT)));
        writeIdx3++;
      end
      if (done3) begin
        doneCount3++;
        doneEdge3 = edgeCount;
      end
    end
  end

  task automatic clearScoreboard();
    loadIdx = 0; writeIdx = 0; doneCount = 0; doneEdge = 0; donePrev = 0; stallCycles = 0;
    loadIdx3 = 0; writeIdx3 = 0; doneCount3 = 0; doneEdge3 = 0; lastWin3 = 0;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_win_valid"}, winValid, 0);
    checkOutput({pfx, "_out_wr_en"}, outWrEn, 0);
    checkOutput({pfx, "_win_row"}, winRow, 0);
    checkOutput({pfx, "_win_col"}, winCol, 0);
    checkOutput({pfx, "_out_row"}, outRow, 0);
    checkOutput({pfx, "_out_col"}, outCol, 0);
    checkOutput({pfx, "_out_data"}, outData, 0);
  endtask

  // Drives a one-cycle start; startEdge is the edge that samples it.
  task automatic applyStimulus(input bit withLat3);
    @(posedge clock); #1;
    start = 1'b1;
    if (withLat3) start3 = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    start3 = 1'b0;
    startEdge = edgeCount;
    checkOutput("first_busy", busy, 1);
    checkOutput("first_win_valid", winValid, 1);
  endtask

  task automatic waitDone(input int budget, input bit withLat3);
    int n = 0;
    while ((doneCount == 0 || (withLat3 && doneCount3 == 0)) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("done_seen", (doneCount != 0) ? 1 : 0, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic waitWindow(input bit wantWrite, input int r, input int c, output bit found);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(posedge clock); #1;
      if (wantWrite && outWrEn && outRow == 3'(r) && outCol == 3'(c)) found = 1;
      if (!wantWrite && winValid && winRow == 3'(r) && winCol == 3'(c)) found = 1;
    end
    checkOutput("window_found", found, 1);
  endtask

  initial begin
    bit found;
    nreset = 0; nreset3 = 0; start = 0; start3 = 0;
    outReady = 1; outReady3 = 1; constMode = 0;
    clearScoreboard();
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("rst");
    nreset = 1; nreset3 = 1;
    @(posedge clock); #1;
    checkOutput("idle_busy", busy, 0);

    $display("[TB] pass A: varied data, CONV_LAT 1 and 3");
    clearScoreboard();
    applyStimulus(1'b1);
    waitDone(400, 1'b1);
    checkOutput("a_done_cycle", doneEdge - startEdge, 108);
    checkOutput("a_done_count", doneCount, 1);
    checkOutput("a_writes", writeIdx, 36);
    checkOutput("a_loads", loadIdx, 36);
    checkOutput("a3_done_cycle", doneEdge3 - startEdge, 180);
    checkOutput("a3_writes", writeIdx3, 36);
    checkOutput("a3_done_count", doneCount3, 1);

    $display("[TB] pass B: constant -5, backpressure at (2,3)");
    clearScoreboard();
    constMode = 1;
    applyStimulus(1'b0);
    waitWindow(1'b1, 2, 3, found);
    outReady = 0;
    repeat (4) begin
      @(posedge clock); #1;
      checkOutput("stall_held_wr_en", outWrEn, 1);
    end
    outReady = 1;
    waitDone(300, 1'b0);
    checkOutput("b_done_cycle", doneEdge - startEdge, 112);
    checkOutput("b_stall_cycles", stallCycles, 4);
    checkOutput("b_writes", writeIdx, 36);
    checkOutput("b_last_data", outData, expData(-8'sd5));

    $display("[TB] pass C: start pulsed while busy");
    clearScoreboard();
    constMode = 0;
    applyStimulus(1'b0);
    repeat (20) @(posedge clock);
    #1 start = 1;
    @(posedge clock); #1 start = 0;
    waitDone(300, 1'b0);
    repeat (30) @(posedge clock);
    #1;
    checkOutput("c_done_cycle", doneEdge - startEdge, 108);
    checkOutput("c_done_count", doneCount, 1);
    checkOutput("c_writes", writeIdx, 36);
    checkOutput("c_idle_busy", busy, 0);

    $display("[TB] pass D: reset during window (3,1), then restart");
    clearScoreboard();
    applyStimulus(1'b0);
    waitWindow(1'b0, 3, 1, found);
    nreset = 0;
    #1;
    checkResetOutputs("midrst");
    clearScoreboard();
    repeat (2) @(posedge clock);
    #1 nreset = 1;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("abort_no_done", doneCount, 0);
    checkOutput("abort_busy", busy, 0);
    applyStimulus(1'b0);
    waitDone(300, 1'b0);
    checkOutput("d_done_cycle", doneEdge - startEdge, 108);
    checkOutput("d_writes", writeIdx, 36);
    checkOutput("d_done_count", doneCount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
